// File: rtl/nfu_pkg.sv
// Shared NFU definitions: lane geometry, accumulator state encoding and the
// saturating lane adder used when N2_SAT_EN is defined.
package nfu_pkg;

    localparam int N  = 16;
    localparam int Tn = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // One extra sign bit exposes overflow: the two top bits disagree only when the N-bit result wrapped.
    function automatic logic signed [N-1:0] lane_sat_add(input logic signed [N-1:0] a,
                                                         input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1]) begin
            return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        return s[N-1:0];
    endfunction

endpackage

// File: rtl/n2_out_fifo.sv
// Result FIFO for the n2 accumulator: pointer-based storage with an extra wrap bit
// and a registered head so the consumer sees a flop-driven data bus.
module n2_out_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [AW:0]      w_rd_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_rd_nxt  = r_rd + (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_din;
        end
    end

    // The head must track the entry rd will point at after this edge; when that entry is being
    // written in the same cycle it is still only on i_din, not yet in r_mem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            o_head <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd <= w_rd_nxt;
                if (w_do_push && (w_rd_nxt == r_wr)) begin
                    o_head <= i_din;
                end else begin
                    o_head <= r_mem[w_rd_nxt[AW-1:0]];
                end
            end else if (w_do_push && o_empty) begin
                o_head <= i_din;
            end
        end
    end

endmodule

// File: rtl/n2_accumulator.sv
// NFU-2 accumulator: sums Tn lane partial sums over a programmed tile count and queues results.
// Build option N2_SAT_EN: lanes saturate on signed overflow instead of wrapping.
module n2_accumulator
    import nfu_pkg::*;
#(
    parameter int N          = nfu_pkg::N,
    parameter int Tn         = nfu_pkg::Tn,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [CNT_W-1:0] i_num_tiles,
    input  logic            i_sum_valid,
    input  logic [Tn*N-1:0] i_sums,
    output logic            o_in_ready,
    output logic [Tn*N-1:0] o_res,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [Tn*N-1:0]  r_acc;
    logic [Tn*N-1:0]  w_acc_nxt;
    logic [Tn*N-1:0]  w_lane_sum;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    for (genvar g = 0; g < Tn; g++) begin : g_lane
`ifdef N2_SAT_EN
        assign w_lane_sum[g*N +: N] = lane_sat_add(r_acc[g*N +: N], i_sums[g*N +: N]);
`else
        assign w_lane_sum[g*N +: N] = r_acc[g*N +: N] + i_sums[g*N +: N];
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        o_in_ready  = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ACCUM;
                    w_count_nxt = (i_num_tiles == '0) ? '0 : i_num_tiles - CNT_W'(1);
                    w_acc_nxt   = '0;
                end
            end
            ACCUM: begin
                o_in_ready = !w_full;
                if (i_sum_valid && !w_full) begin
                    if (r_count != '0) begin
                        w_acc_nxt   = w_lane_sum;
                        w_count_nxt = r_count - CNT_W'(1);
                    end else begin
                        w_push      = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
            o_done  <= w_push;
            o_err   <= o_err | ((r_state == IDLE) && i_sum_valid);
        end
    end

    assign o_busy  = (r_state == ACCUM);
    assign o_valid = !w_empty;

    n2_out_fifo #(
        .WIDTH (Tn*N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_lane_sum),
        .i_pop   (i_ready),
        .o_head  (o_res),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_n2_accumulator.sv
// Bench for n2_accumulator: directed scenarios plus randomized jobs scored against a lane-sum model.
module tb_n2_accumulator;

    localparam int N     = 16;
    localparam int TN    = 16;
    localparam int W     = N*TN;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic [CNT_W-1:0] i_num_tiles = '0;
    logic             i_sum_valid = 1'b0;
    logic [W-1:0]     i_sums = '0;
    logic             i_ready = 1'b0;
    logic             o_in_ready;
    logic [W-1:0]     o_res;
    logic             o_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_pops   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] beat_q[$];
    bit           rnd_ready = 1'b0;
    bit           ready_cmd = 1'b0;

    n2_accumulator #(.N(N), .Tn(TN), .CNT_W(CNT_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_tiles(i_num_tiles),
        .i_sum_valid(i_sum_valid), .i_sums(i_sums), .o_in_ready(o_in_ready),
        .o_res(o_res), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef N2_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`else
        if (s > 32767) s -= 65536;
        else if (s < -32768) s += 65536;
`endif
        return s;
    endfunction

    function automatic logic [W-1:0] bcast(input logic [N-1:0] v);
        logic [W-1:0] r;
        for (int l = 0; l < TN; l++) r[l*N +: N] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] lane_idx(input int mul);
        logic [W-1:0] r;
        for (int l = 0; l < TN; l++) r[l*N +: N] = N'(l*mul);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int l = 0; l < TN; l++) begin
            case ($urandom_range(0, 3))
                0:       r[l*N +: N] = 16'h7FF0 + N'($urandom_range(0, 15));
                1:       r[l*N +: N] = 16'h8000 + N'($urandom_range(0, 15));
                default: r[l*N +: N] = N'($urandom());
            endcase
        end
        return r;
    endfunction

    // Consumer ready: random during the random phase, otherwise commanded by the directed code.
    always @(posedge clk) begin
        #2;
        i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    // Scoreboard: every handshake on the output must deliver the oldest outstanding model result.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_without_expected", W'(exp_q.size()), W'(1));
            end else begin
                check_eq($sformatf("fifo_head_%0d", n_pops), o_res, exp_q.pop_front());
            end
            n_pops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        i_start = 1'b0;
        i_sum_valid = 1'b0;
        i_num_tiles = '0;
        i_sums = '0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        beat_q.delete();
        check_eq("rst_busy", W'(o_busy), '0);
        check_eq("rst_valid", W'(o_valid), '0);
        check_eq("rst_res", o_res, '0);
        check_eq("rst_done", W'(o_done), '0);
        check_eq("rst_err", W'(o_err), '0);
        check_eq("rst_in_ready", W'(o_in_ready), '0);
    endtask

    task automatic start_job(input int tiles);
        i_start = 1'b1;
        i_num_tiles = CNT_W'(tiles);
        tick();
        i_start = 1'b0;
        check_eq("start_busy", W'(o_busy), W'(1));
    endtask

    task automatic send_beat(input logic [W-1:0] b);
        int guard = 0;
        i_sum_valid = 1'b1;
        i_sums = b;
        while (!o_in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!o_in_ready) check_eq("beat_accept_timeout", W'(o_in_ready), W'(1));
        tick();
        i_sum_valid = 1'b0;
    endtask

    task automatic run_job(input int tiles, input bit gaps, input bit do_start);
        int           nb;
        int           acc[TN];
        logic [W-1:0] b;
        logic [W-1:0] e;
        nb = (tiles == 0) ? 1 : tiles;
        if (do_start) start_job(tiles);
        for (int l = 0; l < TN; l++) acc[l] = 0;
        for (int k = 0; k < nb; k++) begin
            b = (beat_q.size() != 0) ? beat_q.pop_front() : rand_beat();
            for (int l = 0; l < TN; l++) acc[l] = model_add(acc[l], int'($signed(b[l*N +: N])));
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (k == nb - 1) begin
                for (int l = 0; l < TN; l++) e[l*N +: N] = N'(acc[l]);
                exp_q.push_back(e);
            end
            send_beat(b);
            if (k != nb - 1) begin
                check_eq("mid_done", W'(o_done), '0);
                check_eq("mid_busy", W'(o_busy), W'(1));
            end
        end
        check_eq("job_done", W'(o_done), W'(1));
        check_eq("job_idle", W'(o_busy), '0);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || o_valid) && g < 400) begin
            tick();
            g++;
        end
        check_eq("drain_empty", W'(exp_q.size()), '0);
    endtask

    task automatic set_ready(input bit r);
        ready_cmd = r;
        repeat (2) tick();
    endtask

    initial begin
        logic [W-1:0] e;
        int           pops0;
        reset_dut();

        // single tile
        beat_q.push_back(bcast(16'd5));
        run_job(1, 0, 1);
        check_eq("t1_valid", W'(o_valid), W'(1));
        check_eq("t1_res", o_res, bcast(16'd5));
        tick();
        check_eq("t1_done_pulse", W'(o_done), '0);
        set_ready(1);
        wait_drain();

        // four-tile job, result only after the last beat
        start_job(4);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(lane_idx(4));
            send_beat(lane_idx(1));
            if (k < 3) check_eq($sformatf("t2_novalid_%0d", k), W'(o_valid), '0);
        end
        check_eq("t2_valid", W'(o_valid), W'(1));
        check_eq("t2_res", o_res, lane_idx(4));
        wait_drain();

        // back-pressure with five queued one-tile jobs
        set_ready(0);
        pops0 = n_pops;
        for (int k = 1; k <= 4; k++) begin
            beat_q.push_back(bcast(N'(k)));
            run_job(1, 0, 1);
        end
        start_job(1);
        check_eq("t3_in_ready_full", W'(o_in_ready), '0);
        i_sum_valid = 1'b1;
        i_sums = bcast(16'd5);
        repeat (3) begin
            tick();
            check_eq("t3_held", W'(o_in_ready), '0);
        end
        beat_q.push_back(bcast(16'd5));
        ready_cmd = 1'b1;
        run_job(1, 0, 0);
        wait_drain();
        check_eq("t3_pop_count", W'(n_pops - pops0), W'(5));

        // lane overflow
        set_ready(0);
        e = '0;
        e[15:0] = 16'h7FFF;
        beat_q.push_back(e);
        e[15:0] = 16'h0001;
        beat_q.push_back(e);
        run_job(2, 0, 1);
`ifdef N2_SAT_EN
        check_eq("t4_lane0", W'(o_res[15:0]), W'(16'h7FFF));
`else
        check_eq("t4_lane0", W'(o_res[15:0]), W'(16'h8000));
`endif
        set_ready(1);
        wait_drain();

        // protocol errors: beat in IDLE, start while busy
        i_sum_valid = 1'b1;
        i_sums = bcast(16'd9);
        tick();
        i_sum_valid = 1'b0;
        check_eq("t5_err", W'(o_err), W'(1));
        tick();
        check_eq("t5_no_push", W'(o_valid), '0);
        start_job(3);
        send_beat(lane_idx(1));
        i_start = 1'b1;
        i_num_tiles = CNT_W'(1);
        tick();
        i_start = 1'b0;
        send_beat(lane_idx(1));
        check_eq("t5_start_ignored", W'(o_valid), '0);
        check_eq("t5_still_busy", W'(o_busy), W'(1));
        exp_q.push_back(lane_idx(3));
        send_beat(lane_idx(1));
        check_eq("t5_valid", W'(o_valid), W'(1));
        check_eq("t5_res", o_res, lane_idx(3));
        check_eq("t5_err_sticky", W'(o_err), W'(1));
        wait_drain();

        // reset mid-job, then a fresh job
        set_ready(0);
        start_job(4);
        send_beat(lane_idx(1));
        send_beat(lane_idx(1));
        reset_dut();
        beat_q.push_back(bcast(16'h1234));
        run_job(1, 0, 1);
        check_eq("t6_res", o_res, bcast(16'h1234));
        set_ready(1);
        wait_drain();

        // randomized jobs under random consumer stalls
        rnd_ready = 1'b1;
        for (int j = 0; j < 25; j++) begin
            run_job($urandom_range(0, 5), 1'b1, 1'b1);
            repeat ($urandom_range(0, 1)) tick();
        end
        rnd_ready = 1'b0;
        ready_cmd = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
